// File: rtl/fetch_pkg.sv
// Shared constants and types for the IF->ID fetch queue.
package fetch_pkg;

  localparam int unsigned FQ_DATA_W = 64;
  localparam int unsigned FQ_EXCP_W = 5;

  // Exception tag carried alongside each fetched instruction.
  typedef struct packed {
    logic [3:0] num;
    logic       valid;
  } fq_excp_t;

endpackage

// File: rtl/fetch_queue_mp_if.sv
// Fetch/decode side of the multi-port fetch queue.
interface fetch_queue_mp_if
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W = FQ_DATA_W,
  parameter int unsigned EXCP_W = FQ_EXCP_W,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned PUSH_N = 2,
  parameter int unsigned POP_N  = 2
) ();

  localparam int unsigned ICW = $clog2(PUSH_N + 1);
  localparam int unsigned OCW = $clog2(POP_N + 1);
  localparam int unsigned CW  = $clog2(DEPTH) + 1;

  logic                     in_valid;
  logic [ICW-1:0]           in_cnt;
  logic [PUSH_N*DATA_W-1:0] in_data;
  logic [PUSH_N*EXCP_W-1:0] in_excp;
  logic                     in_ready;
  logic                     push_fire;
  logic [POP_N-1:0]         out_valid;
  logic [POP_N*DATA_W-1:0]  out_data;
  logic [POP_N*EXCP_W-1:0]  out_excp;
  logic [OCW-1:0]           pop_cnt;
  logic [CW-1:0]            count;

  // Fetch + decode pipeline side.
  modport master (
    output in_valid, in_cnt, in_data, in_excp, pop_cnt,
    input  in_ready, push_fire, out_valid, out_data, out_excp, count
  );

  // The queue itself.
  modport slave (
    input  in_valid, in_cnt, in_data, in_excp, pop_cnt,
    output in_ready, push_fire, out_valid, out_data, out_excp, count
  );

endinterface

// File: rtl/fetch_queue_mp_ptr_ctrl.sv
// Head/tail pointer control for the fetch queue: occupancy, clamping,
// reset/flush priority, per-slot write enables and read indices.
module fq_ptr_ctrl #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned PUSH_N = 2,
  parameter int unsigned POP_N  = 2,
  localparam int unsigned AW  = $clog2(DEPTH),
  localparam int unsigned PW  = AW + 1,
  localparam int unsigned ICW = $clog2(PUSH_N + 1),
  localparam int unsigned OCW = $clog2(POP_N + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [ICW-1:0]           in_cnt,
  input  logic [OCW-1:0]           pop_cnt,
  output logic                     in_ready,
  output logic                     push_fire,
  output logic [PW-1:0]            count,
  output logic [POP_N-1:0]         out_valid,
  output logic [PUSH_N-1:0]        wr_en,
  output logic [PUSH_N-1:0][AW-1:0] wr_idx,
  output logic [POP_N-1:0][AW-1:0]  rd_idx
);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] free_cnt;
  logic [PW-1:0] push_n;
  logic [PW-1:0] pop_req;
  logic [PW-1:0] eff_pop;

  // Occupancy, readiness and clamped push/pop amounts, all from registers
  // plus the request inputs; in_ready deliberately ignores pop_cnt.
  always_comb begin
    count     = head - tail;
    free_cnt  = PW'(DEPTH) - count;
    in_ready  = (free_cnt >= PW'(PUSH_N));
    push_fire = in_valid && in_ready && (in_cnt != '0);
    push_n    = (in_cnt > ICW'(PUSH_N)) ? PW'(PUSH_N) : PW'(in_cnt);
    pop_req   = (pop_cnt > OCW'(POP_N)) ? PW'(POP_N) : PW'(pop_cnt);
    eff_pop   = (pop_req > count) ? count : pop_req;
  end

  // Per-slot write enables/indices (index arithmetic wraps naturally at
  // DEPTH) and thermometer-coded read valids.
  always_comb begin
    wr_en     = '0;
    wr_idx    = '0;
    out_valid = '0;
    rd_idx    = '0;
    for (int unsigned i = 0; i < PUSH_N; i++) begin
      wr_en[i]  = push_fire && !reset && !flush && (PW'(i) < push_n);
      wr_idx[i] = head[AW-1:0] + AW'(i);
    end
    for (int unsigned i = 0; i < POP_N; i++) begin
      out_valid[i] = (count > PW'(i));
      rd_idx[i]    = tail[AW-1:0] + AW'(i);
    end
  end

  // Pointer registers: reset beats flush, flush discards the cycle's push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push_fire) head <= head + push_n;
      tail <= tail + eff_pop;
    end
  end

  a_pop_overrun: assert property (@(posedge clk) disable iff (reset || flush)
                                  (PW'(pop_cnt) <= count))
    else $error("fq_ptr_ctrl: pop_cnt exceeds occupancy");

endmodule

// File: rtl/fetch_queue_mp.sv
// Multi-port instruction fetch queue between IF and ID: up to PUSH_N
// entries in and up to POP_N oldest entries out per cycle, 1-cycle latency.
module fetch_queue_mp
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W = FQ_DATA_W,
  parameter int unsigned EXCP_W = FQ_EXCP_W,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned PUSH_N = 2,
  parameter int unsigned POP_N  = 2
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  fetch_queue_mp_if.slave  fq
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [EXCP_W-1:0] excp_mem [DEPTH];

  logic [PUSH_N-1:0]         wr_en;
  logic [PUSH_N-1:0][AW-1:0] wr_idx;
  logic [POP_N-1:0][AW-1:0]  rd_idx;

  fq_ptr_ctrl #(
    .DEPTH  (DEPTH),
    .PUSH_N (PUSH_N),
    .POP_N  (POP_N)
  ) u_ptr_ctrl (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (fq.in_valid),
    .in_cnt    (fq.in_cnt),
    .pop_cnt   (fq.pop_cnt),
    .in_ready  (fq.in_ready),
    .push_fire (fq.push_fire),
    .count     (fq.count),
    .out_valid (fq.out_valid),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .rd_idx    (rd_idx)
  );

  // Storage writes: each enabled group slot lands at its wrapped index.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PUSH_N; i++) begin
      if (wr_en[i]) begin
        data_mem[wr_idx[i]] <= fq.in_data[i*DATA_W +: DATA_W];
        excp_mem[wr_idx[i]] <= fq.in_excp[i*EXCP_W +: EXCP_W];
      end
    end
  end

  // Combinational read of the POP_N oldest entries, oldest in slot 0.
  always_comb begin
    fq.out_data = '0;
    fq.out_excp = '0;
    for (int unsigned i = 0; i < POP_N; i++) begin
      fq.out_data[i*DATA_W +: DATA_W] = data_mem[rd_idx[i]];
      fq.out_excp[i*EXCP_W +: EXCP_W] = excp_mem[rd_idx[i]];
    end
  end

endmodule

// File: tb/tb_fetch_queue_mp.sv
// Scoreboard bench for fetch_queue_mp against a queue-based reference model.
module tb_fetch_queue_mp;
  import fetch_pkg::*;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned EXCP_W = 5;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned PUSH_N = 2;
  localparam int unsigned POP_N  = 2;
  localparam int unsigned EW     = DATA_W + EXCP_W;

  typedef struct {
    int                             cnt;
    bit                             rdy;
    bit                             pf;
    logic [POP_N-1:0]               ov;
    logic [POP_N-1:0][DATA_W-1:0]   d;
    logic [POP_N-1:0][EXCP_W-1:0]   e;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  fetch_queue_mp_if #(
    .DATA_W (DATA_W), .EXCP_W (EXCP_W), .DEPTH (DEPTH),
    .PUSH_N (PUSH_N), .POP_N (POP_N)
  ) bus ();

  fetch_queue_mp #(
    .DATA_W (DATA_W), .EXCP_W (EXCP_W), .DEPTH (DEPTH),
    .PUSH_N (PUSH_N), .POP_N (POP_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .fq    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] model[$];
  exp_t          exp_q[$];

  // Inputs applied in the previous cycle, replayed into the model after the edge.
  bit                       p_reset = 1'b1;
  bit                       p_flush = 1'b0;
  bit                       p_fire  = 1'b0;
  int                       p_cnt   = 0;
  int                       p_pop   = 0;
  logic [PUSH_N*DATA_W-1:0] p_data;
  logic [PUSH_N*EXCP_W-1:0] p_excp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // One cycle of stimulus: update model for last cycle, drive new inputs,
  // and queue the outputs the monitor should see this cycle.
  task automatic drive(input bit r, input bit f, input bit v, input int c, input int p);
    exp_t x;
    int   n;
    @(posedge clk);
    #1;
    if (p_reset || p_flush) begin
      model.delete();
    end else begin
      n = (p_pop < model.size()) ? p_pop : model.size();
      repeat (n) void'(model.pop_front());
      if (p_fire)
        for (int i = 0; i < p_cnt; i++)
          model.push_back({p_data[i*DATA_W +: DATA_W], p_excp[i*EXCP_W +: EXCP_W]});
    end
    if (p > model.size()) p = model.size();
    reset         = r;
    flush         = f;
    bus.in_valid  = v;
    bus.in_cnt    = 2'(c);
    bus.pop_cnt   = 2'(p);
    for (int i = 0; i < PUSH_N; i++) begin
      bus.in_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
      bus.in_excp[i*EXCP_W +: EXCP_W] = 5'($urandom);
    end
    x.cnt = model.size();
    x.rdy = (DEPTH - model.size()) >= PUSH_N;
    x.pf  = v && x.rdy && (c != 0);
    x.ov  = '0;
    x.d   = '0;
    x.e   = '0;
    for (int i = 0; i < POP_N; i++)
      if (i < model.size()) begin
        x.ov[i] = 1'b1;
        x.d[i]  = model[i][EW-1:EXCP_W];
        x.e[i]  = model[i][EXCP_W-1:0];
      end
    exp_q.push_back(x);
    p_reset = r;
    p_flush = f;
    p_fire  = x.pf;
    p_cnt   = (c > PUSH_N) ? PUSH_N : c;
    p_pop   = p;
    p_data  = bus.in_data;
    p_excp  = bus.in_excp;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check("count", 64'(bus.count), 64'(x.cnt));
        check("in_ready", 64'(bus.in_ready), 64'(x.rdy));
        check("push_fire", 64'(bus.push_fire), 64'(x.pf));
        check("out_valid", 64'(bus.out_valid), 64'(x.ov));
        for (int i = 0; i < POP_N; i++)
          if (x.ov[i]) begin
            check($sformatf("out_data[%0d]", i), bus.out_data[i*DATA_W +: DATA_W], x.d[i]);
            check($sformatf("out_excp[%0d]", i), 64'(bus.out_excp[i*EXCP_W +: EXCP_W]), 64'(x.e[i]));
          end
      end
    end
  end

  initial begin
    int wait_cyc;
    reset = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_cnt = '0; bus.pop_cnt = '0;
    bus.in_data = '0; bus.in_excp = '0;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 1, 2, 0);
    // single group of two, then idle
    drive(0, 0, 1, 2, 0);
    drive(0, 0, 0, 0, 0);
    // fill to 7, then blocked pushes
    drive(0, 0, 1, 2, 0);
    drive(0, 0, 1, 2, 0);
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 2, 0);
    drive(0, 0, 1, 1, 0);
    // drain, leaving head at 7, then push across the wrap point
    drive(0, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 2, 0);
    drive(0, 0, 1, 2, 0);
    // count 4 -> pop 1 to 3, then simultaneous push 2 / pop 2
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 1, 2, 2);
    drive(0, 0, 0, 0, 0);
    // in_cnt beyond PUSH_N clamps
    drive(0, 0, 1, 3, 0);
    drive(0, 0, 0, 0, 0);
    // flush with push and pop in the same cycle
    drive(0, 1, 1, 2, 2);
    drive(0, 0, 0, 0, 2);
    // single-entry drain
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    // randomized traffic
    for (int k = 0; k < 600; k++)
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
            $urandom_range(0, 2));
    drive(0, 0, 0, 0, 0);
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
